// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO for the switch datapath.
// Provides programmable almost-full/almost-empty thresholds, hysteretic pause and sticky error bits.
module fifo_param #(
    parameter int DATA_SIZE = 8,
    parameter int PTR_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in_push,
    input  logic [PTR_SIZE:0]    th_full,
    input  logic [PTR_SIZE:0]    th_empty,
    output logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 valid_out,
    output logic [PTR_SIZE:0]    count,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic [1:0]           fifo_error
);

    localparam int DEPTH = 2 ** PTR_SIZE;
    localparam logic [PTR_SIZE:0]   DEPTH_C  = (PTR_SIZE + 1)'(DEPTH);
    localparam logic [PTR_SIZE:0]   CNT_ZERO = {(PTR_SIZE + 1){1'b0}};
    localparam logic [PTR_SIZE:0]   CNT_ONE  = {{PTR_SIZE{1'b0}}, 1'b1};
    localparam logic [PTR_SIZE-1:0] PTR_ZERO = {PTR_SIZE{1'b0}};
    localparam logic [PTR_SIZE-1:0] PTR_ONE  = {{(PTR_SIZE - 1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } pause_state_t;

    logic [DATA_SIZE-1:0] mem_r [DEPTH];
    logic [PTR_SIZE-1:0]  wr_ptr_r;
    logic [PTR_SIZE-1:0]  rd_ptr_r;
    logic [PTR_SIZE:0]    count_r;
    logic [DATA_SIZE-1:0] data_out_r;
    logic                 valid_r;
    pause_state_t         pause_state_r;
    logic [1:0]           error_r;

    logic empty_s;
    logic full_s;
    logic rd_ok_s;
    logic wr_ok_s;

    assign empty_s = (count_r == CNT_ZERO);
    assign full_s  = (count_r == DEPTH_C);
    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside an accepted pop.
    assign rd_ok_s = read && !empty_s;
    assign wr_ok_s = write && (!full_s || rd_ok_s);

    assign data_out_pop = data_out_r;
    assign valid_out    = valid_r;
    assign count        = count_r;
    assign fifo_empty   = empty_s;
    assign fifo_full    = full_s;
    assign almost_full  = (count_r >= th_full);
    assign almost_empty = (count_r <= th_empty);
    assign fifo_pause   = (pause_state_r == PAUSE);
    assign fifo_error   = error_r;

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset && wr_ok_s) begin
            mem_r[wr_ptr_r] <= data_in_push;
        end
    end

    // Pointers, occupancy, read port, pause hysteresis and sticky errors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            data_out_r    <= {DATA_SIZE{1'b0}};
            valid_r       <= 1'b0;
            pause_state_r <= RUN;
            error_r       <= 2'b00;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                data_out_r <= mem_r[rd_ptr_r];
                valid_r    <= 1'b1;
            end else begin
                valid_r    <= 1'b0;
            end

            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase

            // Set has priority so overlapping thresholds resolve to PAUSE.
            case (pause_state_r)
                RUN: begin
                    if (count_r >= th_full) begin
                        pause_state_r <= PAUSE;
                    end else begin
                        pause_state_r <= RUN;
                    end
                end
                PAUSE: begin
                    if (count_r >= th_full) begin
                        pause_state_r <= PAUSE;
                    end else if (count_r <= th_empty) begin
                        pause_state_r <= RUN;
                    end else begin
                        pause_state_r <= PAUSE;
                    end
                end
                default: pause_state_r <= RUN;
            endcase

            error_r[0] <= error_r[0] | (write && !wr_ok_s);
            error_r[1] <= error_r[1] | (read && empty_s);
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] data_in_push = 8'h00;
    logic [3:0] th_full = 4'd6;
    logic [3:0] th_empty = 4'd2;
    logic [7:0] data_out_pop;
    logic       valid_out;
    logic [3:0] count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_pause;
    logic [1:0] fifo_error;

    fifo_param #(.DATA_SIZE(8), .PTR_SIZE(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .data_in_push (data_in_push),
        .th_full      (th_full),
        .th_empty     (th_empty),
        .data_out_pop (data_out_pop),
        .valid_out    (valid_out),
        .count        (count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_pause   (fifo_pause),
        .fifo_error   (fifo_error)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_pause;
    logic [1:0] m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count",        count,        n);
        check("fifo_empty",   fifo_empty,   (n == 0) ? 1 : 0);
        check("fifo_full",    fifo_full,    (n == 8) ? 1 : 0);
        check("almost_full",  almost_full,  (n >= int'(th_full)) ? 1 : 0);
        check("almost_empty", almost_empty, (n <= int'(th_empty)) ? 1 : 0);
        check("valid_out",    valid_out,    m_valid);
        check("data_out_pop", data_out_pop, m_dout);
        check("fifo_pause",   fifo_pause,   m_pause);
        check("fifo_error",   fifo_error,   m_err);
    endtask

    // One clock: drive inputs, advance model at the edge, compare shortly after.
    task automatic step(input logic rs, input logic w, input logic r, input logic [7:0] d);
        int  n;
        bit  rd_ok;
        bit  wr_ok;
        reset = rs;
        write = w;
        read = r;
        data_in_push = d;
        @(posedge clk);
        n = q.size();
        if (!rs) begin
            q.delete();
            m_dout = 8'h00;
            m_valid = 1'b0;
            m_pause = 1'b0;
            m_err = 2'b00;
        end else begin
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < 8) || rd_ok);
            if (n >= int'(th_full)) m_pause = 1'b1;
            else if (n <= int'(th_empty)) m_pause = 1'b0;
            if (w && !wr_ok) m_err[0] = 1'b1;
            if (r && n == 0) m_err[1] = 1'b1;
            if (rd_ok) begin
                m_dout = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (wr_ok) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        m_dout = 8'h00;
        m_valid = 1'b0;
        m_pause = 1'b0;
        m_err = 2'b00;

        // 1. Reset then fill
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty", fifo_empty, 1);
        check("rst_count", count, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(i));
            if (i == 5) check("af_low_at5", almost_full, 0);
            if (i == 6) check("af_high_at6", almost_full, 1);
            if (i == 6) check("pause_not_yet", fifo_pause, 0);
            if (i == 7) check("pause_after6", fifo_pause, 1);
        end
        check("fill_full", fifo_full, 1);
        check("fill_err", fifo_error, 0);

        // 2. Overflow
        step(1'b1, 1'b1, 1'b0, 8'h99);
        check("ovf_count", count, 8);
        check("ovf_err", fifo_error, 2'b01);

        // 3. Drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("drain_data", data_out_pop, i);
        end
        check("drain_pause", fifo_pause, 0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("udf_err", fifo_error, 2'b11);
        check("udf_valid", valid_out, 0);

        // 4. Simultaneous ops at full and at empty
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        check("sim_full_data", data_out_pop, 8'h10);
        check("sim_full_err", fifo_error, 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        check("sim_last_aa", data_out_pop, 8'hAA);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        check("sim_empty_cnt", count, 1);
        check("sim_empty_err", fifo_error, 2'b10);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("sim_empty_pop", data_out_pop, 8'h55);

        // 5. Wrap-around at occupancy 3
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 8'(8'h40 + i));
        check("wrap_count", count, 3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

        // 6. Mid-operation reset
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        check("pre_rst_pause", fifo_pause, 1);
        check("pre_rst_err", fifo_error, 2'b01);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("mid_rst_count", count, 0);
        check("mid_rst_pause", fifo_pause, 0);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("post_rst_data", data_out_pop, 8'h77);

        // 7. Randomized traffic with changing thresholds and rare resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                th_full = 4'($urandom_range(0, 15));
                th_empty = 4'($urandom_range(0, 9));
            end
            step(($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the fixed 6x8 FIFO used in the PCIe switching datapath.
- Buffers DATA_SIZE-bit words between the switch ingress and egress stages.
- Generalises width and depth and adds runtime-programmable almost-full/almost-empty thresholds, a hysteretic pause (backpressure) output, an occupancy count and split sticky overflow/underflow error bits.

Parameters:
- DATA_SIZE, 8, word width in bits.
- PTR_SIZE, 3, pointer width. DEPTH = 2**PTR_SIZE entries (default 8).

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  reset is synchronous and active-low.
- write  input  1  push request.
- read  input  1  pop request.
- data_in_push  input  DATA_SIZE  push data.
- th_full  input  PTR_SIZE+1  almost-full / pause-set threshold.
- th_empty  input  PTR_SIZE+1  almost-empty / pause-release threshold.
- data_out_pop  output  DATA_SIZE  popped word, registered.
- valid_out  output  1  data_out_pop holds a word popped last cycle.
- count  output  PTR_SIZE+1  current occupancy, 0..DEPTH.
- fifo_empty  output  1  count==0.
- fifo_full  output  1  count==DEPTH.
- almost_full  output  1  count>=th_full.
- almost_empty  output  1  count<=th_empty.
- fifo_pause  output  1  registered backpressure with hysteresis.
- fifo_error  output  2  sticky: bit0 overflow, bit1 underflow.

Behaviour:
- Reset: when reset==0 at a posedge, pointers and count clear to 0. data_out_pop=0, valid_out=0, fifo_pause=0, fifo_error=2'b00. Memory contents are not cleared. write/read are ignored in that cycle.
- Reset status flags: fifo_empty=1, fifo_full=0. almost_full and almost_empty follow their formulas with count=0.
- Read accept (rd_ok): read && !fifo_empty.
- Write accept (wr_ok): write && (!fifo_full || rd_ok). A push into a full FIFO with a simultaneous accepted pop is legal.
- No fall-through: write+read on an empty FIFO accepts only the write (rd_ok=0) and flags underflow.
- Pointers: wr_ok writes mem[wr_ptr] and increments wr_ptr; rd_ok increments rd_ptr. Both wrap modulo DEPTH.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Read latency is 1 cycle. On rd_ok, at the next edge data_out_pop<=mem[rd_ptr] and valid_out<=1. Otherwise valid_out<=0 and data_out_pop holds its last value.
- fifo_empty, fifo_full, almost_full and almost_empty are combinational from the count register, so they reflect an operation one cycle after its edge.
- fifo_pause register, evaluated each edge on the current count:
  - count>=th_full: set to 1.
  - else count<=th_empty: clear to 0.
  - else: hold.
  - If thresholds overlap, set wins.
  - Two states, RUN (0) and PAUSE (1). fifo_pause is advisory: the FIFO still accepts writes while paused.
- Overflow: write && !wr_ok sets fifo_error[0]. Underflow: read && fifo_empty sets fifo_error[1].
- Error bits are sticky until reset. A rejected operation changes no pointer, count or data.
- Thresholds may change at any time and take effect on the next evaluation. th_full>DEPTH means almost_full and pause-set never fire.

Test Plan (DATA_SIZE=8, PTR_SIZE=3, th_full=6, th_empty=2):
1. Reset then fill: hold reset=0 for 2 cycles, then push 0x01..0x08 on consecutive cycles.
   - Required: count steps 1..8; almost_full first high when count=6; fifo_pause high the cycle after count=6 is observed; fifo_full=1 at count=8; fifo_error=00.
2. Overflow: at count=8, write=1 with 0x99 and read=0.
   - Required: count stays 8; fifo_error=01 from next cycle and stays sticky; 0x99 is never read out.
3. Drain and order: pop 8 times.
   - Required: data_out_pop 0x01..0x08, each with valid_out=1 one cycle after its read.
   - fifo_pause stays 1 until count<=2 is observed, then 0.
   - fifo_empty=1 at the end; a 9th read sets fifo_error[1] (error=11) and leaves valid_out=0.
4. Simultaneous ops: at count=8, write 0xAA and read together.
   - Required: count stays 8, no overflow, oldest word popped, 0xAA appended.
   - On an empty FIFO, write+read together: count becomes 1, underflow set, valid_out=0.
5. Wrap-around: push/pop 20 words with occupancy held at 3.
   - Required: data order preserved across pointer wrap; count constant 3; no error.
6. Mid-operation reset: reset=0 at count=5 with pause=1 and error=01.
   - Required: next cycle count=0, fifo_empty=1, fifo_pause=0, fifo_error=00, valid_out=0; the next push/pop returns the new data, not stale data.
